// File: rtl/mvm_relu_quant_buf.sv
// ============================================================================
// Module   : mvm_relu_quant_buf
// Brief    : Captures a serial MVM result vector, applies ReLU, rounding shift
//            and saturation, then drains 8-bit activations over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvm_relu_quant_buf #(
  parameter int M     = 32,
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mvm_done,
  input  logic [IN_W-1:0]  data_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             sat_flag,
  output logic             overrun
);

  localparam int                 c_cnt_w = (M > 1) ? $clog2(M) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(M - 1);
  localparam logic [IN_W:0]      c_max   = (IN_W + 1)'((1 << (OUT_W - 1)) - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_wr_cnt;
  logic [c_cnt_w-1:0]   r_rd_cnt;
  logic [OUT_W-1:0]     r_buf [M];
  logic [OUT_W-1:0]     r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic                 r_sat;
  logic                 r_ovr;

  logic [IN_W:0]        w_relu;
  logic [IN_W:0]        w_s;
  logic                 w_sat;
  logic [OUT_W-1:0]     w_q;
  logic [c_cnt_w-1:0]   w_rd_nxt;

  // One extra bit of headroom so the rounding add can never wrap.
  assign w_relu = data_in[IN_W-1] ? '0 : {1'b0, data_in};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [IN_W:0] c_half = (IN_W + 1)'(1) << (SHIFT - 1);
      assign w_s = (w_relu + c_half) >> SHIFT;
    end else begin : g_pass
      assign w_s = w_relu;
    end
  endgenerate

  assign w_sat    = (w_s > c_max);
  assign w_q      = w_sat ? c_max[OUT_W-1:0] : w_s[OUT_W-1:0];
  assign w_rd_nxt = r_rd_cnt + c_cnt_w'(1);

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state != IDLE);
  assign sat_flag  = r_sat;
  assign overrun   = r_ovr;

  always_ff @(posedge clk) begin
    if (reset && (r_state == CAPTURE)) begin
      r_buf[r_wr_cnt] <= w_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_sat       <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      // A done pulse outside IDLE never restarts the sequence; it is only flagged.
      if (mvm_done && (r_state != IDLE)) begin
        r_ovr <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (mvm_done) begin
            r_state  <= CAPTURE;
            r_wr_cnt <= '0;
          end
        end
        CAPTURE: begin
          if (w_sat) begin
            r_sat <= 1'b1;
          end
          if (r_wr_cnt == c_last) begin
            r_state     <= DRAIN;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b1;
            // Element 0 is already in the buffer unless it is being written now.
            r_out_data  <= (r_wr_cnt == '0) ? w_q : r_buf[0];
            r_out_last  <= (c_last == '0);
          end else begin
            r_wr_cnt <= r_wr_cnt + c_cnt_w'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_rd_cnt == c_last) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_rd_cnt   <= w_rd_nxt;
              r_out_data <= r_buf[w_rd_nxt];
              r_out_last <= (w_rd_nxt == c_last);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mvm_relu_quant_buf.sv
// ============================================================================
// Module   : tb_mvm_relu_quant_buf
// Brief    : Self-checking bench: vector tables feed a scoreboard queue that a
//            stream monitor drains; hand-written sequences cover the corners.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mvm_relu_quant_buf;

  typedef struct {
    logic [15:0] y;
    logic [7:0]  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mvm_done;
  logic [15:0] data_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        sat_flag;
  logic        overrun;

  logic        d0_done;
  logic [15:0] d0_data;
  logic [7:0]  d0_out;
  logic        d0_valid;
  logic        d0_ready;
  logic        d0_last;
  logic        d0_busy;
  logic        d0_sat;
  logic        d0_ovr;

  vec_t        tbl [10];
  logic [15:0] ys [32];
  logic [7:0]  es [32];
  logic [7:0]  exp_q [$];
  logic [7:0]  d0_exp [3];

  int   nchk = 0;
  int   nerr = 0;
  int   acc  = 0;
  int   ready_mode = 0;
  logic hold_v = 1'b0;
  logic [7:0] hold_d = '0;
  logic hold_l = 1'b0;
  logic drop_chk = 1'b0;

  always #5 clk = ~clk;

  mvm_relu_quant_buf dut (
    .clk       (clk),
    .reset     (reset),
    .mvm_done  (mvm_done),
    .data_in   (data_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .sat_flag  (sat_flag),
    .overrun   (overrun)
  );

  mvm_relu_quant_buf #(.M(32), .IN_W(16), .OUT_W(8), .SHIFT(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .mvm_done  (d0_done),
    .data_in   (d0_data),
    .out_data  (d0_out),
    .out_valid (d0_valid),
    .out_ready (d0_ready),
    .out_last  (d0_last),
    .busy      (d0_busy),
    .sat_flag  (d0_sat),
    .overrun   (d0_ovr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input int bound);
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (!busy) return;
    end
    nchk++;
    nerr++;
    $display("FAIL idle_timeout: busy=%0d after %0d cycles, expected 0", busy, bound);
  endtask

  task automatic load_table();
    for (int i = 0; i < 32; i++) begin
      ys[i] = (i < 10) ? tbl[i].y : 16'd0;
      es[i] = (i < 10) ? tbl[i].e : 8'd0;
    end
  endtask

  // Pulses mvm_done now; it is sampled at the next posedge, then 32 words follow.
  task automatic send(input bit chk_sat, input int od_at, input int abort_at);
    mvm_done = 1'b1;
    @(posedge clk); #1;
    mvm_done = 1'b0;
    for (int i = 0; i < 32; i++) begin
      data_in  = ys[i];
      mvm_done = (i == od_at);
      if (i == abort_at) reset = 1'b0;
      else exp_q.push_back(es[i]);
      @(posedge clk); #1;
      if (i == abort_at) begin
        reset    = 1'b1;
        mvm_done = 1'b0;
        data_in  = '0;
        exp_q.delete();
        check("abort_valid", out_valid, 0);
        check("abort_last", out_last, 0);
        check("abort_busy", busy, 0);
        check("abort_sat", sat_flag, 0);
        check("abort_ovr", overrun, 0);
        check("abort_data", out_data, 0);
        return;
      end
      if (i == 0) check("busy_capture", busy, 1);
      if (chk_sat && i == 4) check("sat_before_e5", sat_flag, 0);
      if (chk_sat && i == 5) check("sat_after_e5", sat_flag, 1);
      if (i == 30) check("valid_early", out_valid, 0);
    end
    mvm_done = 1'b0;
    data_in  = '0;
    check("first_valid", out_valid, 1);
  endtask

  // Ready pattern generator: constant high, or 1,0,0,1 repeating.
  initial begin
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (ready_mode == 1) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else out_ready = 1'b1;
    end
  end

  // Stream monitor / scoreboard consumer.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (drop_chk) begin
        check("busy_drop", busy, 0);
        drop_chk = 1'b0;
      end
      if (reset === 1'b1 && out_valid === 1'b1) begin
        if (hold_v) begin
          check("hold_data", out_data, hold_d);
          check("hold_last", out_last, hold_l);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL extra_word: got %0d, expected no word", out_data);
          end else begin
            e = exp_q.pop_front();
            check("drain_data", out_data, e);
            check("drain_last", out_last, (acc % 32) == 31);
            acc++;
            if ((acc % 32) == 0) begin
              check("busy_at_last", busy, 1);
              drop_chk = 1'b1;
            end
          end
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold_d = out_data;
          hold_l = out_last;
        end
      end else if (hold_v) begin
        check("hold_valid", out_valid, 1);
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b0;
    mvm_done = 1'b0;
    data_in  = '0;
    d0_done  = 1'b0;
    d0_data  = '0;
    d0_ready = 1'b1;
    tbl[0] = '{16'hFF9C, 8'd0};
    tbl[1] = '{16'h0000, 8'd0};
    tbl[2] = '{16'd23,   8'd1};
    tbl[3] = '{16'd24,   8'd2};
    tbl[4] = '{16'd2039, 8'd127};
    tbl[5] = '{16'd2040, 8'd127};
    tbl[6] = '{16'h7FFF, 8'd127};
    tbl[7] = '{16'h8000, 8'd0};
    tbl[8] = '{16'd7,    8'd0};
    tbl[9] = '{16'd8,    8'd1};
    d0_exp[0] = 8'd127;
    d0_exp[1] = 8'd127;
    d0_exp[2] = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_ovr", overrun, 0);
    check("rst_data", out_data, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic stream, ready always high
    load_table();
    acc = 0;
    send(1'b1, -1, -1);
    wait_idle(200);
    check("t1_count", acc, 32);
    check("t1_sat", sat_flag, 1);
    check("t1_ovr", overrun, 0);
    check("t1_queue", exp_q.size(), 0);

    // Backpressure 1,0,0,1
    @(posedge clk); #1;
    ready_mode = 1;
    acc = 0;
    send(1'b0, -1, -1);
    wait_idle(400);
    check("t2_count", acc, 32);
    check("t2_queue", exp_q.size(), 0);
    ready_mode = 0;

    // Overrun during capture and during drain
    @(posedge clk); #1;
    acc = 0;
    send(1'b0, 10, -1);
    check("t3_ovr_capture", overrun, 1);
    mvm_done = 1'b1;
    @(posedge clk); #1;
    mvm_done = 1'b0;
    check("t3_ovr_drain", overrun, 1);
    wait_idle(200);
    repeat (5) @(negedge clk);
    check("t3_no_restart", busy, 0);
    check("t3_count", acc, 32);
    check("t3_queue", exp_q.size(), 0);

    // Reset at capture element 15, then a clean ramp
    @(posedge clk); #1;
    load_table();
    send(1'b0, -1, 15);
    for (int j = 0; j < 32; j++) begin
      ys[j] = 16'(16 * j);
      es[j] = 8'(j);
    end
    acc = 0;
    send(1'b0, -1, -1);
    wait_idle(200);
    check("t4_count", acc, 32);

    // Back-to-back: done on the first IDLE cycle
    for (int j = 0; j < 32; j++) begin
      ys[j] = 16'hFFFF;
      es[j] = 8'd0;
    end
    acc = 0;
    send(1'b0, -1, -1);
    wait_idle(200);
    check("t5_count", acc, 32);
    check("t5_ovr", overrun, 0);
    check("t5_sat", sat_flag, 0);

    // SHIFT=0 instance
    @(posedge clk); #1;
    d0_done = 1'b1;
    @(posedge clk); #1;
    d0_done = 1'b0;
    for (int i = 0; i < 32; i++) begin
      d0_data = (i == 0) ? 16'd127 : (i == 1) ? 16'd128 : (i == 2) ? 16'hFFFB : 16'd0;
      @(posedge clk); #1;
      if (i == 0) check("s0_sat_127", d0_sat, 0);
      if (i == 1) check("s0_sat_128", d0_sat, 1);
    end
    d0_data = '0;
    check("s0_valid", d0_valid, 1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("s0_data", d0_out, d0_exp[j]);
    end
    begin
      int c;
      for (c = 0; c < 100; c++) begin
        @(negedge clk);
        if (!d0_busy) break;
      end
      check("s0_idle", d0_busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

`default_nettype wire
